// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment driver with binary-to-BCD/hex conversion
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int VAL_WIDTH   = 17,
    parameter int REFRESH_DIV = 262144
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [VAL_WIDTH-1:0] val_in,
    input  logic                 val_valid_in,
    input  logic                 hex_mode_in,
    input  logic                 blank_lz_in,
    output logic                 ready_out,
    output logic                 ovf_out,
    output logic [DIGITS-1:0]    an_out,
    output logic [6:0]           seg_out
);

    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(VAL_WIDTH + 1);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [VAL_WIDTH-1:0] shift_q, shift_d;
    logic [NW-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 cvt_ovf_q, cvt_ovf_d;
    logic                 cvt_hex_q, cvt_hex_d;
    logic                 cvt_blank_q, cvt_blank_d;
    logic [NW-1:0]        disp_nib_q, disp_nib_d;
    logic                 disp_ovf_q, disp_ovf_d;
    logic                 disp_hex_q, disp_hex_d;
    logic                 disp_blank_q, disp_blank_d;
    logic                 ready_q, ready_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           cur_nib;
    logic                 upper_zero;

    function automatic logic [6:0] decode(input logic [3:0] n, input logic hx);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (!hx && n > 4'd9) begin
            g = 7'b0101010;
        end
        return g;
    endfunction

    // Conversion FSM and display-register commit. In hex mode the add-3 step is
    // skipped, so the same MSB carry-out rule flags latched bits above the
    // displayable nibbles as overflow.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        cvt_ovf_d    = cvt_ovf_q;
        cvt_hex_d    = cvt_hex_q;
        cvt_blank_d  = cvt_blank_q;
        disp_nib_d   = disp_nib_q;
        disp_ovf_d   = disp_ovf_q;
        disp_hex_d   = disp_hex_q;
        disp_blank_d = disp_blank_q;
        bcd_adj      = bcd_q;
        if (!cvt_hex_q) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bcd_q[4*i +: 4] >= 4'd5) begin
                    bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
            end
        end
        case (state_q)
            S_IDLE: begin
                if (val_valid_in && ready_q) begin
                    shift_d     = val_in;
                    bcd_d       = '0;
                    cnt_d       = CW'(VAL_WIDTH);
                    cvt_ovf_d   = 1'b0;
                    cvt_hex_d   = hex_mode_in;
                    cvt_blank_d = blank_lz_in;
                    state_d     = S_CONV;
                end
            end
            S_CONV: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                if (bcd_adj[NW-1]) begin
                    cvt_ovf_d = 1'b1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_nib_d   = bcd_q;
                disp_ovf_d   = cvt_ovf_q;
                disp_hex_d   = cvt_hex_q;
                disp_blank_d = cvt_blank_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Scan timing and glyph selection. an/seg follow the index held during the
    // previous cycle so every digit, including the first after reset, is lit
    // for exactly REFRESH_DIV cycles; the glyph uses the incoming display
    // register so seg_out and ovf_out switch on the commit edge together.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == '0) ? IW'(DIGITS - 1) : idx_q - IW'(1);
        end
        cur_nib    = 4'd0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_q) begin
                cur_nib = disp_nib_d[4*j +: 4];
            end
            if (IW'(j) >= idx_q && disp_nib_d[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        an_d = ~(DIGITS'(1) << idx_q);
        if (disp_ovf_d) begin
            seg_d = 7'b1111110;
        end else if (disp_blank_d && idx_q != '0 && upper_zero) begin
            seg_d = 7'b1111111;
        end else begin
            seg_d = decode(cur_nib, disp_hex_d);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            cvt_ovf_q    <= 1'b0;
            cvt_hex_q    <= 1'b0;
            cvt_blank_q  <= 1'b0;
            disp_nib_q   <= '0;
            disp_ovf_q   <= 1'b0;
            disp_hex_q   <= 1'b0;
            disp_blank_q <= 1'b0;
            ready_q      <= 1'b0;
            presc_q      <= '0;
            idx_q        <= IW'(DIGITS - 1);
            an_q         <= '1;
            seg_q        <= 7'b1111111;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            cvt_ovf_q    <= cvt_ovf_d;
            cvt_hex_q    <= cvt_hex_d;
            cvt_blank_q  <= cvt_blank_d;
            disp_nib_q   <= disp_nib_d;
            disp_ovf_q   <= disp_ovf_d;
            disp_hex_q   <= disp_hex_d;
            disp_blank_q <= disp_blank_d;
            ready_q      <= ready_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign ready_out = ready_q;
    assign ovf_out   = disp_ovf_q;
    assign an_out    = an_q;
    assign seg_out   = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int VW = 17;
    localparam int RD = 4;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [VW-1:0] val_in;
    logic          val_valid_in;
    logic          hex_mode_in;
    logic          blank_lz_in;
    logic          ready_out;
    logic          ovf_out;
    logic [D-1:0]  an_out;
    logic [6:0]    seg_out;

    int n_checks = 0;
    int n_err    = 0;

    seg7_scan_driver #(.DIGITS(D), .VAL_WIDTH(VW), .REFRESH_DIV(RD)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .val_in(val_in),
        .val_valid_in(val_valid_in), .hex_mode_in(hex_mode_in),
        .blank_lz_in(blank_lz_in), .ready_out(ready_out), .ovf_out(ovf_out),
        .an_out(an_out), .seg_out(seg_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ipow(input int b, input int e);
        int r = 1;
        repeat (e) r = r * b;
        return r;
    endfunction

    function automatic logic [6:0] glyph_of(input int n);
        case (n)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;  10: return 7'b0001000; 11: return 7'b1100000;
            12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic bit m_ovf(input int v, input bit hx);
        return v >= ipow(hx ? 16 : 10, D);
    endfunction

    function automatic logic [6:0] m_seg(input int v, input bit hx, input bit bl, input int k);
        int base = hx ? 16 : 10;
        if (m_ovf(v, hx)) return 7'b1111110;
        if (bl && k > 0 && v < ipow(base, k)) return 7'b1111111;
        return glyph_of((v / ipow(base, k)) % base);
    endfunction

    // Reference model: tracks edges since reset release, the pending value and
    // the committed value, and compares all outputs every cycle.
    bit m_live = 0;
    bit m_ready;
    int m_cnt, rel;
    int d_val, p_val;
    bit d_hex, d_blank, p_hex, p_blank;

    always @(posedge clk_in) begin
        bit r, vv, hx, bl, acc;
        int v, k;
        logic [D-1:0] ea;
        r = rst_n_in; vv = val_valid_in; v = int'(val_in); hx = hex_mode_in; bl = blank_lz_in;
        if (!r) begin
            m_live = 1; m_ready = 0; m_cnt = 0; rel = -1;
            d_val = 0; d_hex = 0; d_blank = 0;
        end else if (m_live) begin
            rel++;
            acc = m_ready && vv;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    d_val = p_val; d_hex = p_hex; d_blank = p_blank;
                end
            end else if (acc) begin
                p_val = v; p_hex = hx; p_blank = bl; m_cnt = VW + 1;
            end
            m_ready = (m_cnt == 0);
        end
        #1;
        if (m_live) begin
            if (!r) begin
                check("rst_an", an_out, {D{1'b1}});
                check("rst_seg", seg_out, 7'b1111111);
                check("rst_ready", ready_out, 0);
                check("rst_ovf", ovf_out, 0);
            end else begin
                k = D - 1 - ((rel / RD) % D);
                ea = '1;
                ea[k] = 1'b0;
                check("an_out", an_out, ea);
                check("seg_out", seg_out, m_seg(d_val, d_hex, d_blank, k));
                check("ready_out", ready_out, m_ready);
                check("ovf_out", ovf_out, m_ovf(d_val, d_hex));
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready_out && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        check("ready_wait", ready_out, 1);
    endtask

    task automatic submit(input int v, input bit hx, input bit bl);
        int lowcnt = 0;
        wait_ready();
        val_valid_in = 1; val_in = VW'(v); hex_mode_in = hx; blank_lz_in = bl;
        @(negedge clk_in);
        val_valid_in = 0;
        while (!ready_out && lowcnt < 100) begin
            lowcnt++;
            @(negedge clk_in);
        end
        check("busy_cycles", lowcnt, VW + 1);
    endtask

    // e packs digit 3..0 glyphs, digit 0 in the low 7 bits.
    task automatic expect_scan(input string nm, input logic [27:0] e, input logic eovf);
        int k;
        check({nm, "_ovf"}, ovf_out, eovf);
        for (int c = 0; c < D * RD; c++) begin
            case (an_out)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            if (k < 0) check({nm, "_an_onehot"}, an_out, 4'b1110);
            else check({nm, "_seg"}, seg_out, e[7*k +: 7]);
            @(negedge clk_in);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1);
    end

    initial begin
        int hold, sel;
        rst_n_in = 0; val_valid_in = 0; val_in = '0; hex_mode_in = 0; blank_lz_in = 0;
        repeat (3) @(negedge clk_in);
        check("lit_rst_an", an_out, 4'b1111);
        check("lit_rst_seg", seg_out, 7'b1111111);
        check("lit_rst_ready", ready_out, 0);
        rst_n_in = 1;
        @(negedge clk_in);
        check("lit_rel_ready", ready_out, 1);
        check("lit_rel_an", an_out, 4'b0111);
        check("lit_rel_seg", seg_out, 7'b0000001);
        repeat (3) begin
            @(negedge clk_in);
            check("lit_hold_d3", an_out, 4'b0111);
        end
        @(negedge clk_in);
        check("lit_step_d2", an_out, 4'b1011);

        submit(1234, 0, 0);
        expect_scan("dec1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 0);
        submit(99999, 0, 0);
        expect_scan("dec99999", {4{7'b1111110}}, 1);
        submit(9999, 0, 0);
        expect_scan("dec9999", {4{7'b0000100}}, 0);
        submit(7, 0, 1);
        expect_scan("blank7", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}, 0);
        submit(0, 0, 1);
        expect_scan("blank0", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 0);
        submit(1005, 0, 1);
        expect_scan("blank1005", {7'b1001111, 7'b0000001, 7'b0000001, 7'b0100100}, 0);
        submit(32'h0BEEF, 1, 0);
        expect_scan("hex0beef", {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}, 0);
        submit(32'h1BEEF, 1, 0);
        expect_scan("hex1beef", {4{7'b1111110}}, 1);

        wait_ready();
        val_valid_in = 1; val_in = VW'(4321); hex_mode_in = 0; blank_lz_in = 0;
        repeat (12) begin
            @(negedge clk_in);
            val_in = VW'($urandom_range(0, 99999));
            hex_mode_in = 1'($urandom_range(0, 1));
            blank_lz_in = 1'($urandom_range(0, 1));
        end
        val_valid_in = 0;
        wait_ready();
        expect_scan("first_only", {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111}, 0);

        wait_ready();
        val_valid_in = 1; val_in = VW'(5678); hex_mode_in = 0; blank_lz_in = 1;
        @(negedge clk_in);
        val_valid_in = 0;
        repeat (5) @(negedge clk_in);
        rst_n_in = 0;
        repeat (2) @(negedge clk_in);
        check("lit_midrst_ready", ready_out, 0);
        rst_n_in = 1;
        @(negedge clk_in);
        check("lit_after_rst_ready", ready_out, 1);
        check("lit_after_rst_an", an_out, 4'b0111);
        expect_scan("aborted", {4{7'b0000001}}, 0);

        for (int t = 0; t < 60; t++) begin
            wait_ready();
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            hold = $urandom_range(1, 25);
            val_valid_in = 1;
            repeat (hold) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: val_in = VW'($urandom_range(0, 20));
                    1: val_in = VW'($urandom_range(0, 9999));
                    2: val_in = VW'($urandom_range(0, (1 << VW) - 1));
                    default: begin
                        case ($urandom_range(0, 5))
                            0: val_in = VW'(9999);
                            1: val_in = VW'(10000);
                            2: val_in = VW'(65535);
                            3: val_in = VW'(65536);
                            4: val_in = VW'(1);
                            default: val_in = '0;
                        endcase
                    end
                endcase
                hex_mode_in = 1'($urandom_range(0, 1));
                blank_lz_in = 1'($urandom_range(0, 1));
                @(negedge clk_in);
            end
            val_valid_in = 0;
        end
        wait_ready();
        repeat (D * RD) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
